// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for a small RISC-V style
// opcode subset, raises datapath strobes for each step and counts retired
// instructions. Unsupported opcodes park the controller in TRAP until reset.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src_imm,
  output logic [1:0]       alu_op,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_IALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JALR,
    C_ILL
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_LOAD   = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  state_t    cur_state;
  state_t    next_state;
  op_class_t op_class;

  assign state = cur_state;

  // Classify the instruction register opcode into the supported groups.
  always_comb begin
    case (opcode)
      OP_R:      op_class = C_R;
      OP_IALU:   op_class = C_IALU;
      OP_LOAD:   op_class = C_LOAD;
      OP_STORE:  op_class = C_STORE;
      OP_BRANCH: op_class = C_BRANCH;
      OP_JALR:   op_class = C_JALR;
      default:   op_class = C_ILL;
    endcase
  end

  // Datapath strobes and next-state selection for the current step.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    rf_we       = 1'b0;
    wb_sel      = WB_ALU;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    retire      = 1'b0;
    illegal     = 1'b0;
    next_state  = cur_state;

    case (cur_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        next_state = (op_class == C_ILL) ? S_TRAP : S_EXEC;
      end

      S_EXEC: begin
        alu_src_imm = (op_class == C_IALU) || (op_class == C_LOAD) ||
                      (op_class == C_STORE) || (op_class == C_JALR);
        case (op_class)
          C_R, C_IALU: begin
            alu_op     = ALU_FUNCT;
            next_state = S_WB;
          end
          C_JALR:           next_state = S_WB;
          C_LOAD, C_STORE:  next_state = S_MEM;
          C_BRANCH: begin
            alu_op     = ALU_CMP;
            pc_we      = 1'b1;
            pc_sel     = br_taken ? PC_BRANCH : PC_PLUS4;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          default:          next_state = S_TRAP;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_class == C_STORE);
        if (dmem_ack) begin
          if (op_class == C_STORE) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
        case (op_class)
          C_LOAD:  wb_sel = WB_LOAD;
          C_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JALR;
          end
          default: wb_sel = WB_ALU;
        endcase
      end

      S_TRAP: begin
        illegal    = 1'b1;
        next_state = S_TRAP;
      end

      default: next_state = S_FETCH;
    endcase

    // While reset is held every strobe is forced low so nothing downstream
    // (memories, PC, register file) acts on a half-initialised controller.
    if (!rst_n) begin
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = ALU_ADD;
      rf_we       = 1'b0;
      wb_sel      = WB_ALU;
      pc_we       = 1'b0;
      pc_sel      = PC_PLUS4;
      retire      = 1'b0;
      illegal     = 1'b0;
    end
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      cur_state  <= S_FETCH;
      retire_cnt <= '0;
    end else begin
      cur_state <= next_state;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard testbench for multicycle_ctrl.
// The driver issues directed instructions and pushes the expected retire
// record; a negedge monitor tracks each instruction and compares on retire.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        imem_ack, dmem_ack, br_taken;

  logic        imem_req, ir_we, dmem_req, dmem_we, alu_src_imm, rf_we;
  logic        pc_we, retire, illegal;
  logic [1:0]  alu_op, wb_sel, pc_sel;
  logic [2:0]  state;
  logic [31:0] retire_cnt;

  logic        imem_req_4, ir_we_4, dmem_req_4, dmem_we_4, alu_src_imm_4, rf_we_4;
  logic        pc_we_4, retire_4, illegal_4;
  logic [1:0]  alu_op_4, wb_sel_4, pc_sel_4;
  logic [2:0]  state_4;
  logic [3:0]  retire_cnt_4;

  logic [13:0] strobes;
  assign strobes = {imem_req, ir_we, dmem_req, dmem_we, alu_src_imm, alu_op,
                    rf_we, wb_sel, pc_we, pc_sel, retire};

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .br_taken(br_taken), .imem_req(imem_req),
    .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .rf_we(rf_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
    .illegal(illegal), .state(state), .retire_cnt(retire_cnt)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .br_taken(br_taken), .imem_req(imem_req_4),
    .ir_we(ir_we_4), .dmem_req(dmem_req_4), .dmem_we(dmem_we_4),
    .alu_src_imm(alu_src_imm_4), .alu_op(alu_op_4), .rf_we(rf_we_4),
    .wb_sel(wb_sel_4), .pc_we(pc_we_4), .pc_sel(pc_sel_4), .retire(retire_4),
    .illegal(illegal_4), .state(state_4), .retire_cnt(retire_cnt_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [31:0] trace;
    int          imem_n;
    int          irwe_n;
    int          dreq_n;
    int          dwe_n;
    int          rfwe_n;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [1:0]  wb_sel;
    logic [1:0]  pc_sel;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected state sequence, packed 3 bits per cycle.
  function automatic logic [31:0] exp_trace(input int iw, input bit mem,
                                            input int dw, input bit wb);
    logic [31:0] t = 0;
    for (int i = 0; i <= iw; i++) t = {t[28:0], 3'd0};
    t = {t[28:0], 3'd1};
    t = {t[28:0], 3'd2};
    if (mem) for (int i = 0; i <= dw; i++) t = {t[28:0], 3'd3};
    if (wb) t = {t[28:0], 3'd4};
    return t;
  endfunction

  // Issue one legal instruction; iw/dw are fetch/data wait cycles, noisy
  // holds the acks high in every cycle where they must be ignored.
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw,
                           input bit br, input bit noisy);
    exp_t e;
    bit   mem, wb;
    int   m0;
    mem = (op == OP_LOAD) || (op == OP_STORE);
    wb  = (op != OP_STORE) && (op != OP_BRANCH);
    e.lat     = iw + 3 + (mem ? dw + 1 : 0) + (wb ? 1 : 0);
    e.trace   = exp_trace(iw, mem, dw, wb);
    e.imem_n  = iw + 1;
    e.irwe_n  = 1;
    e.dreq_n  = mem ? dw + 1 : 0;
    e.dwe_n   = (op == OP_STORE) ? dw + 1 : 0;
    e.rfwe_n  = wb ? 1 : 0;
    e.alu_op  = (op == OP_R || op == OP_IALU) ? 2'b10 :
                (op == OP_BRANCH) ? 2'b01 : 2'b00;
    e.alu_src = (op == OP_IALU) || mem || (op == OP_JALR);
    e.wb_sel  = (op == OP_LOAD) ? 2'b01 : (op == OP_JALR) ? 2'b10 : 2'b00;
    e.pc_sel  = (op == OP_JALR) ? 2'b10 : (op == OP_BRANCH && br) ? 2'b01 : 2'b00;
    e.cnt     = model_cnt;
    exp_q.push_back(e);
    model_cnt = model_cnt + 1;

    opcode   = op;
    br_taken = br;
    m0       = iw + 3;
    for (int c = 0; c < e.lat; c++) begin
      imem_ack = noisy ? (c >= iw) : (c == iw);
      dmem_ack = noisy ? !(mem && c >= m0 && c < m0 + dw) : (mem && c == m0 + dw);
      step();
    end
  endtask

  // Hold reset with acks high; outputs must stay quiet and state/counter clear.
  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("reset_strobes", 32'(strobes), 32'h0);
      check("reset_illegal", 32'(illegal), 32'h0);
      step();
    end
    check("reset_state", 32'(state), 32'h0);
    check("reset_cnt", retire_cnt, 32'h0);
    check("reset_cnt4", 32'(retire_cnt_4), 32'h0);
    model_cnt = 0;
    rst_n     = 1'b1;
    imem_ack  = 1'b0;
    dmem_ack  = 1'b0;
    #1;
    check("first_imem_req", 32'(imem_req), 32'h1);
  endtask

  // Monitor: tracks the in-flight instruction and scores every retire.
  bit          fresh = 1'b1;
  bit          prev_retire = 1'b0;
  logic [2:0]  prev_state = 3'd0;
  int          m_lat, m_imem, m_irwe, m_dreq, m_dwe, m_rfwe;
  logic [31:0] m_trace;
  logic [1:0]  m_alu_op;
  logic        m_alu_src;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      fresh = 1'b1;
      prev_retire = 1'b0;
    end else begin
      if (fresh || prev_retire || (state == 3'd0 && prev_state != 3'd0)) begin
        m_lat = 0; m_imem = 0; m_irwe = 0; m_dreq = 0; m_dwe = 0; m_rfwe = 0;
        m_trace = 0; m_alu_op = 2'b11; m_alu_src = 1'b0;
        fresh = 1'b0;
      end
      m_lat++;
      m_trace = {m_trace[28:0], state};
      if (imem_req) m_imem++;
      if (ir_we)    m_irwe++;
      if (dmem_req) m_dreq++;
      if (dmem_we)  m_dwe++;
      if (rf_we)    m_rfwe++;
      if (state == 3'd2) begin
        m_alu_op  = alu_op;
        m_alu_src = alu_src_imm;
      end
      if (retire) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_retire: got retire=1 expected no retire at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("latency", 32'(m_lat), 32'(e.lat));
          check("state_trace", m_trace, e.trace);
          check("imem_req_cycles", 32'(m_imem), 32'(e.imem_n));
          check("ir_we_cycles", 32'(m_irwe), 32'(e.irwe_n));
          check("dmem_req_cycles", 32'(m_dreq), 32'(e.dreq_n));
          check("dmem_we_cycles", 32'(m_dwe), 32'(e.dwe_n));
          check("rf_we_cycles", 32'(m_rfwe), 32'(e.rfwe_n));
          check("exec_alu_op", 32'(m_alu_op), 32'(e.alu_op));
          check("exec_alu_src_imm", 32'(m_alu_src), 32'(e.alu_src));
          check("retire_wb_sel", 32'(wb_sel), 32'(e.wb_sel));
          check("retire_pc_sel", 32'(pc_sel), 32'(e.pc_sel));
          check("retire_pc_we", 32'(pc_we), 32'h1);
          check("retire_illegal", 32'(illegal), 32'h0);
          check("retire_cnt", retire_cnt, e.cnt);
          check("retire_cnt4", 32'(retire_cnt_4), 32'(e.cnt[3:0]));
        end
      end
      prev_state  = state;
      prev_retire = retire;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    opcode   = OP_R;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    br_taken = 1'b0;
    step();
    do_reset(2);

    // R-type with imem_ack tied high, then a LOAD with 2 data wait cycles.
    run_instr(OP_R,      0, 0, 1'b0, 1'b1);
    run_instr(OP_LOAD,   0, 2, 1'b0, 1'b0);
    // Taken then not-taken branch.
    run_instr(OP_BRANCH, 0, 0, 1'b1, 1'b1);
    run_instr(OP_BRANCH, 0, 0, 1'b0, 1'b0);
    // Remaining classes with assorted wait patterns and ignored acks.
    run_instr(OP_IALU,   2, 0, 1'b0, 1'b0);
    run_instr(OP_JALR,   1, 0, 1'b1, 1'b1);
    run_instr(OP_STORE,  0, 1, 1'b0, 1'b1);
    run_instr(OP_LOAD,   1, 0, 1'b0, 1'b1);

    // Reset while a LOAD waits in MEM with dmem_ack asserted.
    opcode   = OP_LOAD;
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    step();
    step();
    step();
    @(negedge clk);
    check("abort_in_mem", 32'(state), 32'h3);
    check("abort_dmem_req", 32'(dmem_req), 32'h1);
    step();
    do_reset(1);

    // 17 back-to-back stores: 4-bit counter wraps and ends at 1.
    for (int i = 0; i < 17; i++) run_instr(OP_STORE, 0, 0, 1'b0, i[0]);
    @(negedge clk);
    check("cnt_after_stores", retire_cnt, 32'd17);
    check("cnt4_after_wrap", 32'(retire_cnt_4), 32'd1);
    step();

    // JAL is unsupported: DECODE must divert to TRAP and stay there.
    opcode   = OP_JAL;
    imem_ack = 1'b1;
    step();
    @(negedge clk);
    check("jal_decode_state", 32'(state), 32'h1);
    check("jal_decode_strobes", 32'(strobes), 32'h0);
    step();
    for (int i = 0; i < 10; i++) begin
      imem_ack = i[0];
      dmem_ack = !i[0];
      br_taken = i[1];
      @(negedge clk);
      check("trap_state", 32'(state), 32'h5);
      check("trap_illegal", 32'(illegal), 32'h1);
      check("trap_strobes", 32'(strobes), 32'h0);
      step();
    end
    check("trap_cnt_held", retire_cnt, 32'd17);
    check("trap_cnt4_held", 32'(retire_cnt_4), 32'd1);

    // Reset releases TRAP and normal operation resumes.
    do_reset(1);
    run_instr(OP_R, 0, 0, 1'b0, 1'b0);
    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
